// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the MISC-V memory path.
//   - default RAM geometry, also used where raw_memory is instantiated
//   - rd_owner_t: which port owns the read currently returning from the RAM
package misc_v_mem_pkg;

  localparam int MEM_DATA_WIDTH    = 16;
  localparam int MEM_ADDR_WIDTH    = 10;
  localparam int MEM_STARVE_LIMIT  = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DATA,
    OWN_FETCH
  } rd_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between the arbiter, its two requesters and the RAM.
//   data port  : d_req/d_we/d_addr/d_wdata in, d_gnt/d_rvalid/d_rdata out
//   fetch port : i_req/i_addr in, i_gnt/i_rvalid/i_rdata out
//   RAM side   : mem_addr/mem_data/mem_we out, mem_q in
// slave  = arbiter view, master = requester/RAM environment view.
interface mem_arbiter_if
  import misc_v_mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_q,
    output d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
           mem_addr, mem_data, mem_we
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr, mem_q,
    input  d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
           mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles the fetch port lost arbitration.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one more lost cycle (ignored once saturated)
//   clr        : clear (fetch was granted)
//   cnt        : current count
//   sat        : cnt has reached LIMIT
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  assign sat = (cnt == MAX);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && !sat)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM (one-cycle registered read) between
// the data (load/store) port and the instruction-fetch port.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave -- both request ports and the RAM side
// Data wins contention unless fetch has lost STARVE_LIMIT cycles in a row.
// Read data returns one cycle after the grant, tagged by rd_owner.
module mem_arbiter
  import misc_v_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             d_win;
  logic             i_win;
  logic             starve_sat;
  logic [CNT_W-1:0] starve_cnt;
  rd_owner_t        rd_owner;

  starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.i_req && !i_win),
    .clr   (i_win),
    .cnt   (starve_cnt),
    .sat   (starve_sat)
  );

  // Grant: fully combinational so a request is accepted in its own cycle.
  always_comb begin
    d_win = 1'b0;
    i_win = 1'b0;
    if (!reset) begin
      if (bus.d_req && bus.i_req) begin
        i_win = starve_sat;
        d_win = !starve_sat;
      end else begin
        d_win = bus.d_req;
        i_win = bus.i_req;
      end
    end
  end

  // RAM drive; address parks at 0 when nobody is granted.
  always_comb begin
    bus.mem_addr = '0;
    if (d_win)
      bus.mem_addr = bus.d_addr;
    else if (i_win)
      bus.mem_addr = bus.i_addr;
  end

  assign bus.mem_data = bus.d_wdata;
  assign bus.mem_we   = d_win && bus.d_we;

  assign bus.d_gnt = d_win;
  assign bus.i_gnt = i_win;

  // Owner of the read whose data appears on mem_q in the next cycle.
  // Stores leave it at none so they never raise rvalid.
  always_ff @(posedge clk) begin
    if (reset)
      rd_owner <= OWN_NONE;
    else if (d_win && !bus.d_we)
      rd_owner <= OWN_DATA;
    else if (i_win)
      rd_owner <= OWN_FETCH;
    else
      rd_owner <= OWN_NONE;
  end

  assign bus.d_rvalid = (rd_owner == OWN_DATA);
  assign bus.i_rvalid = (rd_owner == OWN_FETCH);
  assign bus.d_rdata  = bus.mem_q;
  assign bus.i_rdata  = bus.mem_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model (expected memory contents,
// lost-cycle count, pending read owner) plus explicit grant-pattern checks.
module tb_mem_arbiter;
  import misc_v_mem_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM environment: registered read, write at edge ending the grant cycle.
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
    ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_q = ram_q;

  // Reference model state
  logic [DW-1:0] exp_mem [1<<AW];
  int            m_cnt;
  int            m_own;     // 0 none, 1 data, 2 fetch
  logic [DW-1:0] m_rdata;
  bit            m_dg, m_ig;
  // Observed values from the last cycle, for scenario-level checks
  logic          o_dg, o_ig, o_irv;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit dr, input bit dwe, input int da,
                       input int dwd, input bit ir, input int ia);
    reset       = r;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = AW'(da);
    bus.d_wdata = DW'(dwd);
    bus.i_req   = ir;
    bus.i_addr  = AW'(ia);
  endtask

  // One clock cycle: check at negedge, advance model, return 1 after posedge.
  task automatic cycle();
    bit eg_d, eg_i;
    int eaddr;
    @(negedge clk);
    eg_d = 0;
    eg_i = 0;
    if (!reset) begin
      if (bus.d_req && bus.i_req) begin
        if (m_cnt >= LIM) eg_i = 1; else eg_d = 1;
      end else if (bus.d_req) eg_d = 1;
      else if (bus.i_req) eg_i = 1;
    end
    eaddr = eg_d ? int'(bus.d_addr) : eg_i ? int'(bus.i_addr) : 0;
    chk("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
    chk("i_gnt", 32'(bus.i_gnt), 32'(eg_i));
    chk("mem_we", 32'(bus.mem_we), 32'(eg_d && bus.d_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
    if (eg_d && bus.d_we) chk("mem_data", 32'(bus.mem_data), 32'(bus.d_wdata));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_own == 1));
    chk("i_rvalid", 32'(bus.i_rvalid), 32'(m_own == 2));
    if (m_own == 1) chk("d_rdata", 32'(bus.d_rdata), 32'(m_rdata));
    if (m_own == 2) chk("i_rdata", 32'(bus.i_rdata), 32'(m_rdata));
    chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_cnt));
    o_dg  = bus.d_gnt;
    o_ig  = bus.i_gnt;
    o_irv = bus.i_rvalid;
    // model advance for the coming edge
    if (eg_d && !bus.d_we) begin
      m_own = 1; m_rdata = exp_mem[bus.d_addr];
    end else if (eg_i) begin
      m_own = 2; m_rdata = exp_mem[bus.i_addr];
    end else m_own = 0;
    if (eg_d && bus.d_we) exp_mem[bus.d_addr] = bus.d_wdata;
    if (reset || eg_i) m_cnt = 0;
    else if (bus.i_req && m_cnt < LIM) m_cnt++;
    m_dg = eg_d;
    m_ig = eg_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit dr, dwe, ir;
    int da, dwd, ia;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = DW'(i * 37 + 5);
      exp_mem[i] = DW'(i * 37 + 5);
    end
    ram[10'h010]     = 16'hBEEF;
    exp_mem[10'h010] = 16'hBEEF;
    m_cnt = 0; m_own = 0; m_rdata = '0; m_dg = 0; m_ig = 0;

    // Reset held with both ports requesting
    drive(1, 1, 0, 'h020, 0, 1, 'h010);
    repeat (3) cycle();
    // Release: data wins first
    drive(0, 1, 0, 'h020, 0, 1, 'h010);
    cycle();
    chk("release_d_first", 32'(o_dg), 32'd1);

    // Fetch only from 0x010
    drive(0, 0, 0, 0, 0, 1, 'h010);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("fetch_beef_valid", 32'(o_irv), 32'd1);

    // Store 0x1234 to 0x3FF, then load it back
    drive(0, 1, 1, 'h3FF, 'h1234, 0, 0);
    cycle();
    drive(0, 1, 0, 'h3FF, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Contention for 15 cycles: D,D,D,D,I x3
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, k[0], 'h100 + k, 'hA000 + k, 1, 'h010 + k);
      cycle();
      chk("contention_i_gnt", 32'(o_ig), 32'(k % 5 == 4));
    end

    // Reset arrives the cycle after a fetch grant
    drive(0, 0, 0, 0, 0, 1, 'h010);
    cycle();
    drive(1, 0, 0, 0, 0, 1, 'h011);
    cycle();
    chk("rst_mid_rvalid", 32'(o_irv), 32'd1);
    cycle();
    chk("rst_mid_rvalid_gone", 32'(o_irv), 32'd0);
    chk("rst_mid_cnt", 32'(dut.starve_cnt), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Idle hold: lose 2, drop 3 (count holds), then 2 more losses then win
    drive(0, 1, 0, 'h050, 0, 1, 'h060);
    repeat (2) cycle();
    drive(0, 1, 0, 'h051, 0, 0, 'h060);
    repeat (3) cycle();
    chk("idle_hold_cnt", 32'(dut.starve_cnt), 32'd2);
    drive(0, 1, 0, 'h052, 0, 1, 'h061);
    cycle(); chk("idle_win0", 32'(o_ig), 32'd0);
    cycle(); chk("idle_win1", 32'(o_ig), 32'd0);
    cycle(); chk("idle_win2", 32'(o_ig), 32'd1);

    // Random traffic; a request not yet granted is held unchanged
    dr = 0; dwe = 0; da = 0; dwd = 0; ir = 0; ia = 0;
    for (int k = 0; k < 400; k++) begin
      if (!dr || m_dg) begin
        dr  = ($urandom_range(0, 3) != 0);
        dwe = $urandom_range(0, 1) == 1;
        da  = int'($urandom_range(0, 15)) + 10'h200;
        dwd = int'($urandom_range(0, 16'hFFFF));
      end
      if (!ir || m_ig) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = int'($urandom_range(0, 15)) + 10'h200;
      end
      drive($urandom_range(0, 40) == 0, dr, dwe, da, dwd, ir, ia);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port `raw_memory` (16-bit data, 10-bit address, one-cycle registered read) between the instruction-fetch path and the load/store path of the MISC-V core. Each cycle it grants at most one requester and drives the RAM's `addr`/`data`/`we`. It returns read data to the granted port one cycle later with a valid strobe. The data port has priority, and a starvation counter guarantees fetch forward progress.

## Interface
- `DATA_WIDTH`, 16, RAM word width.
- `ADDR_WIDTH`, 10, RAM address width.
- `STARVE_LIMIT`, 4, consecutive lost cycles after which fetch overrides data priority (must be ≥1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `d_req`  in  1  data-port request, held until `d_gnt`.
- `d_we`  in  1  data-port write enable (1 = store, 0 = load).
- `d_addr`  in  ADDR_WIDTH  data-port address.
- `d_wdata`  in  DATA_WIDTH  data-port store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  `d_rdata` valid (load granted previous cycle).
- `d_rdata`  out  DATA_WIDTH  load data.
- `i_req`  in  1  fetch request (read only), held until `i_gnt`.
- `i_addr`  in  ADDR_WIDTH  fetch address.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_rvalid`  out  1  `i_rdata` valid.
- `i_rdata`  out  DATA_WIDTH  fetched word.
- `mem_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `mem_data`  out  DATA_WIDTH  to RAM `data`.
- `mem_we`  out  1  to RAM `we`.
- `mem_q`  in  DATA_WIDTH  from RAM `q`.

## Operation
- Grant logic is combinational from requests, `reset` and the starvation counter:
  - `reset`=1: no grant.
  - Only one port requesting: that port wins.
  - Both requesting: data wins unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- `d_gnt`/`i_gnt` are one-hot or zero. A requester that sees `gnt`=1 drops or changes `req` in the next cycle.
- Memory drive:
  - Granted port's address goes to `mem_addr`.
  - `mem_we = d_gnt & d_we`.
  - `mem_data = d_wdata`.
  - With no grant: `mem_addr` = 0 and `mem_we` = 0.
- In-flight register `rd_owner` (2 bits: none/data/fetch) is set at each edge to the owner of a granted read, or to none.
  - `d_rvalid = (rd_owner==data)`, `i_rvalid = (rd_owner==fetch)`.
  - `d_rdata` and `i_rdata` both equal `mem_q` and are meaningful only under their own valid.
  - Writes never produce `rvalid`.
- Starvation counter `starve_cnt`, width `$clog2(STARVE_LIMIT+1)`:
  - Increments, saturating at `STARVE_LIMIT`, each cycle `i_req & ~i_gnt`.
  - Clears on `i_gnt` or `reset`.
  - Holds when `i_req`=0.
- Back-to-back grants are allowed every cycle, in any mix of ports and read/write.

## Timing
- Grant: 0-cycle latency, same cycle as `req`.
- Read data: `rvalid` exactly 1 cycle after the granted load or fetch. Throughput is 1 access/cycle total.
- Store: committed at the edge ending the grant cycle.
- Store then load to the same address in consecutive cycles: the load returns the new value (RAM read address is registered after the write).
- Reset values: `rd_owner` = none, so both `rvalid` = 0. `starve_cnt` = 0. `d_gnt` = `i_gnt` = `mem_we` = 0 and `mem_addr` = 0 while `reset` is high.
- Reset mid-operation: a read granted in the cycle before `reset` rises still produces its `rvalid` in the first reset cycle. `rd_owner` is none from the edge at which `reset` is sampled high. No `rvalid` appears in the cycle after reset deasserts unless a grant occurred.
- With `STARVE_LIMIT`=4 and both ports continuously requesting, fetch is granted on every 5th cycle, so fetch waits at most 4 cycles.

## Structure
- Shared package `misc_v_mem_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_FETCH} rd_owner_t`.
  - Default `DATA_WIDTH` and `ADDR_WIDTH` constants, also used by `raw_memory` instantiations.
- One natural sub-module `starve_counter`: saturating counter with `inc`, `clr`, `sat` outputs.
- Everything else is flat in `mem_arbiter`. `raw_memory` is instantiated by the parent, not inside the arbiter.

## Test plan
- Reset: hold `reset` 3 cycles with `d_req`=`i_req`=1. Required: no grants, `mem_we`=0, no `rvalid`. On release, first cycle gives `d_gnt`=1.
- Fetch only: `i_req` with `i_addr`=0x010 and the RAM preloaded with 0x010→0xBEEF. Required: `i_gnt` the same cycle, `i_rvalid`=1 with `i_rdata`=0xBEEF the next cycle, `d_rvalid`=0.
- Store/load: store 0x1234 to 0x3FF, then load 0x3FF on the next cycle. Required: `mem_we` pulses once, `d_rvalid` comes 1 cycle after the load grant, `d_rdata`=0x1234.
- Contention: both ports request continuously for 15 cycles with `STARVE_LIMIT`=4. Required: grant pattern D,D,D,D,I repeated 3 times, and each `i_rvalid` follows its `i_gnt` by one cycle.
- Reset mid-read: a fetch is granted in cycle n and `reset` is asserted in cycle n+1. Required: `i_rvalid`=1 in n+1, 0 thereafter, and `starve_cnt` reads 0.
- Idle hold: `i_req`=1 loses 2 cycles, then drops for 3 cycles, then both request. Required: the counter holds at 2, and fetch wins after 2 further losses.
